// File: rtl/rtrt_pkg.sv
// Shared frame-buffer constants and types for the ray-tracer display subsystem.
package rtrt_pkg;

  localparam int unsigned H_RES    = 640;
  localparam int unsigned V_RES    = 480;
  localparam int unsigned FB_WORDS = H_RES * V_RES;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 4;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [DATA_W-1:0] pix_t;
  typedef logic [9:0]        coord_t;

  typedef enum logic [1:0] {
    PH_DISP = 2'd0,
    PH_WR1  = 2'd1,
    PH_WR2  = 2'd2,
    PH_WR3  = 2'd3
  } fb_phase_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } fb_arb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to a linear frame-buffer address and flags whether it lies on screen.
module fb_addr_calc
  import rtrt_pkg::*;
(
  input  coord_t   x_i,
  input  coord_t   y_i,
  output fb_addr_t addr_o,
  output logic     in_range_o
);

  fb_addr_t x_ext;
  fb_addr_t y_ext;

  assign x_ext = {9'd0, x_i};
  assign y_ext = {9'd0, y_i};

  // 640*y as two shifts so no multiplier is inferred.
  assign addr_o     = x_ext + (y_ext << 9) + (y_ext << 7);
  assign in_range_o = (x_i < coord_t'(H_RES)) && (y_i < coord_t'(V_RES));

endmodule

// File: rtl/fb_port_arbiter.sv
// Time-slot arbiter for the single-port frame buffer: display read in phase 0,
// ray-tracer writes or the clear engine in phases 1-3.
module fb_port_arbiter
  import rtrt_pkg::*;
#(
  parameter int unsigned CLR_WORDS = FB_WORDS
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  coord_t   disp_x_i,
  input  coord_t   disp_y_i,
  output pix_t     disp_pixel_o,
  output logic     disp_valid_o,
  input  logic     wr_valid_i,
  input  coord_t   wr_x_i,
  input  coord_t   wr_y_i,
  input  pix_t     wr_data_i,
  output logic     wr_ready_o,
  input  logic     clr_start_i,
  input  pix_t     clr_data_i,
  output logic     clr_busy_o,
  output logic     clr_done_o,
  output logic [7:0] drop_cnt_o,
  output fb_addr_t mem_addr_o,
  output logic     mem_we_o,
  output pix_t     mem_din_o,
  input  pix_t     mem_dout_i
);

  localparam fb_addr_t LAST_PTR = fb_addr_t'(CLR_WORDS - 1);

  fb_phase_t     ph_q, ph_d;
  fb_arb_state_t state_q, state_d;
  fb_addr_t      ptr_q, ptr_d;
  pix_t          clr_data_q, clr_data_d;
  logic          clr_done_q, clr_done_d;
  logic [7:0]    drop_q, drop_d;
  logic          disp_inr_q;
  pix_t          disp_pix_q;
  logic          disp_vld_q;

  fb_addr_t disp_addr, wr_addr;
  logic     disp_inr, wr_inr;
  logic     is_wslot;

  fb_addr_calc u_disp_addr (
    .x_i        (disp_x_i),
    .y_i        (disp_y_i),
    .addr_o     (disp_addr),
    .in_range_o (disp_inr)
  );

  fb_addr_calc u_wr_addr (
    .x_i        (wr_x_i),
    .y_i        (wr_y_i),
    .addr_o     (wr_addr),
    .in_range_o (wr_inr)
  );

  assign is_wslot = (ph_q != PH_DISP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q       <= PH_DISP;
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      clr_data_q <= '0;
      clr_done_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ph_q       <= ph_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_data_q <= clr_data_d;
      clr_done_q <= clr_done_d;
      drop_q     <= drop_d;
    end
  end

  // Read data returns during phase 1; it is captured at the end of phase 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_inr_q <= 1'b0;
      disp_pix_q <= '0;
      disp_vld_q <= 1'b0;
    end else begin
      if (ph_q == PH_DISP) disp_inr_q <= disp_inr;
      if (ph_q == PH_WR1)  disp_pix_q <= disp_inr_q ? mem_dout_i : '0;
      disp_vld_q <= (ph_q == PH_WR1);
    end
  end

  always_comb begin
    ph_d       = fb_phase_t'(ph_q + 2'd1);
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_data_d = clr_data_q;
    clr_done_d = 1'b0;
    drop_d     = drop_q;
    wr_ready_o = 1'b0;
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    mem_din_o  = '0;

    if (!is_wslot) mem_addr_o = disp_addr;

    case (state_q)
      ARB_IDLE: begin
        wr_ready_o = is_wslot;
        if (wr_valid_i && is_wslot) begin
          if (wr_inr) begin
            mem_addr_o = wr_addr;
            mem_we_o   = 1'b1;
            mem_din_o  = wr_data_i;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
        if (clr_start_i) begin
          state_d    = ARB_CLEAR;
          ptr_d      = '0;
          clr_data_d = clr_data_i;
        end
      end
      ARB_CLEAR: begin
        if (is_wslot) begin
          mem_addr_o = ptr_q;
          mem_we_o   = 1'b1;
          mem_din_o  = clr_data_q;
          ptr_d      = ptr_q + fb_addr_t'(1);
          if (ptr_q == LAST_PTR) begin
            state_d    = ARB_IDLE;
            clr_done_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // The memory must never see a write while reset is held, even combinationally.
    if (!rst_ni) begin
      wr_ready_o = 1'b0;
      mem_we_o   = 1'b0;
    end
  end

  assign disp_pixel_o = disp_pix_q;
  assign disp_valid_o = disp_vld_q;
  assign clr_busy_o   = (state_q == ARB_CLEAR);
  assign clr_done_o   = clr_done_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: frame-buffer memory, behavioural model and directed scenarios.
module tb_fb_port_arbiter;
  import rtrt_pkg::*;

  localparam int N = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] disp_x = 10'd5, disp_y = 10'd2;
  logic [3:0] disp_pixel;
  logic       disp_valid;
  logic       wr_valid = 1'b0;
  logic [9:0] wr_x = '0, wr_y = '0;
  logic [3:0] wr_data = '0;
  logic       wr_ready;
  logic       clr_start = 1'b0;
  logic [3:0] clr_data = '0;
  logic       clr_busy, clr_done;
  logic [7:0] drop_cnt;
  logic [18:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_din;
  logic [3:0] mem_dout;

  logic [3:0] mem [FB_WORDS];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.CLR_WORDS(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .disp_x_i     (disp_x),
    .disp_y_i     (disp_y),
    .disp_pixel_o (disp_pixel),
    .disp_valid_o (disp_valid),
    .wr_valid_i   (wr_valid),
    .wr_x_i       (wr_x),
    .wr_y_i       (wr_y),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .clr_start_i  (clr_start),
    .clr_data_i   (clr_data),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .drop_cnt_o   (drop_cnt),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_din_o    (mem_din),
    .mem_dout_i   (mem_dout)
  );

  // Synchronous-read single-port memory; two known pixels are seeded during reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1285] <= 4'hA;
      mem[1980] <= 4'hF;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: cycle phase, clear progress, drop count, display pipeline.
  int         m_ph = 0;
  bit         m_clr = 0;
  int         m_ptr = 0;
  int         m_cval = 0;
  int         m_drop = 0;
  bit         m_done = 0;
  int         m_pix = 0;
  bit         m_valid = 0;
  bit         m_rd_ok = 0;
  int         m_rd_val = 0;

  function automatic bit on_screen(int x, int y);
    return (x < 640) && (y < 480);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_clr = 0; m_ptr = 0; m_cval = 0; m_drop = 0;
      m_done = 0; m_pix = 0; m_valid = 0; m_rd_ok = 0; m_rd_val = 0;
    end else begin
      m_done  = 0;
      m_valid = (m_ph == 1);
      if (m_ph == 0) begin
        m_rd_ok = on_screen(int'(disp_x), int'(disp_y));
        m_rd_val = m_rd_ok ? int'(mem[int'(disp_x) + 640 * int'(disp_y)]) : 0;
      end
      if (m_ph == 1) m_pix = m_rd_ok ? m_rd_val : 0;
      if (m_clr) begin
        if (m_ph != 0) begin
          m_ptr++;
          if (m_ptr == N) begin
            m_clr  = 0;
            m_done = 1;
          end
        end
      end else begin
        if (wr_valid && m_ph != 0 && !on_screen(int'(wr_x), int'(wr_y)) && m_drop < 255)
          m_drop++;
        if (clr_start) begin
          m_clr  = 1;
          m_ptr  = 0;
          m_cval = int'(clr_data);
        end
      end
      m_ph = (m_ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    int ea, edin;
    bit ewe, erdy;
    if (clr_done) done_cnt++;
    erdy = rst_n && !m_clr && (m_ph != 0);
    ewe  = 0;
    ea   = 0;
    edin = 0;
    if (m_ph == 0) ea = int'(disp_x) + 640 * int'(disp_y);
    else if (m_clr) begin
      ea = m_ptr; ewe = 1; edin = m_cval;
    end else if (wr_valid && on_screen(int'(wr_x), int'(wr_y))) begin
      ea = int'(wr_x) + 640 * int'(wr_y); ewe = 1; edin = int'(wr_data);
    end
    if (!rst_n) ewe = 0;
    chk("mem_addr", int'(mem_addr), ea);
    chk("mem_we", int'(mem_we), int'(ewe));
    if (ewe) chk("mem_din", int'(mem_din), edin);
    chk("wr_ready", int'(wr_ready), int'(erdy));
    chk("clr_busy", int'(clr_busy), int'(m_clr));
    chk("clr_done", int'(clr_done), int'(m_done));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("disp_pixel", int'(disp_pixel), m_pix);
    chk("disp_valid", int'(disp_valid), int'(m_valid));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(int p);
    for (int i = 0; i < 8 && m_ph != p; i++) step();
    chk("phase_align", m_ph, p);
  endtask

  int wx[5] = '{0, 10, 639, 0, 100};
  int wy[5] = '{0, 3, 0, 479, 200};
  int wd[5] = '{1, 2, 5, 9, 12};

  initial begin
    int  cnt;
    bit  got;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Display read of (5,2).
    @(negedge clk);
    chk("lit_disp_addr", int'(mem_addr), 1285);
    chk("lit_disp_no_we", int'(mem_we), 0);
    step();
    step();
    @(negedge clk);
    chk("lit_disp_pix", int'(disp_pixel), 'hA);
    chk("lit_disp_valid", int'(disp_valid), 1);

    // Corner write held from phase 0.
    wait_ph(0);
    wr_valid = 1'b1; wr_x = 10'd639; wr_y = 10'd479; wr_data = 4'd7;
    @(negedge clk);
    chk("lit_corner_rdy_ph0", int'(wr_ready), 0);
    step();
    @(negedge clk);
    chk("lit_corner_rdy", int'(wr_ready), 1);
    chk("lit_corner_addr", int'(mem_addr), 307199);
    chk("lit_corner_we", int'(mem_we), 1);
    chk("lit_corner_din", int'(mem_din), 7);
    step();
    wr_valid = 1'b0;

    // Directed in-range writes.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_x = 10'(wx[i]); wr_y = 10'(wy[i]); wr_data = 4'(wd[i]);
      if (m_ph == 0) step();
      step();
    end
    wr_valid = 1'b0;

    // Read back (10,3) which was written with 2.
    disp_x = 10'd10; disp_y = 10'd3;
    wait_ph(0);
    step();
    step();
    @(negedge clk);
    chk("lit_readback", int'(disp_pixel), 2);

    // Off-screen display coordinate reads as 0 even though memory holds F.
    disp_x = 10'd700; disp_y = 10'd2;
    wait_ph(0);
    step();
    step();
    @(negedge clk);
    chk("lit_disp_oor", int'(disp_pixel), 0);
    disp_x = 10'd5; disp_y = 10'd2;

    // Dropped writes and saturation.
    wait_ph(1);
    wr_valid = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 4'd4;
    @(negedge clk);
    chk("lit_drop_no_we", int'(mem_we), 0);
    step();
    chk("lit_drop_one", int'(drop_cnt), 1);
    repeat (399) step();
    chk("lit_drop_sat", int'(drop_cnt), 255);
    wr_valid = 1'b0;

    // Clear with a simultaneous accepted write.
    wait_ph(1);
    wr_valid = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_data = 4'd6;
    clr_start = 1'b1; clr_data = 4'd3;
    @(negedge clk);
    chk("lit_clr_same_cycle_addr", int'(mem_addr), 641);
    step();
    clr_start = 1'b0; clr_data = 4'd9;
    cnt = 0; got = 0;
    while (cnt < 2000 && !got) begin
      @(negedge clk);
      if (clr_done) got = 1;
      else begin
        step();
        cnt++;
      end
    end
    chk("lit_clear_cycles", cnt, 1600);
    wr_valid = 1'b0;
    step();
    chk("lit_done_once", done_cnt, 1);
    chk("lit_mem0", int'(mem[0]), 3);
    chk("lit_mem_last", int'(mem[N-1]), 3);
    chk("lit_mem_untouched", int'(mem[1285]), 'hA);

    // Reset in the middle of a clear.
    clr_start = 1'b1; clr_data = 4'd5;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 2000 && m_ptr != 1000; i++) step();
    chk("lit_ptr_reached", m_ptr, 1000);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_busy", int'(clr_busy), 0);
    chk("lit_rst_we", int'(mem_we), 0);
    chk("lit_rst_rdy", int'(wr_ready), 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (2000) step();
    chk("lit_no_done_after_abort", done_cnt, 1);
    chk("lit_partial_999", int'(mem[999]), 5);
    chk("lit_partial_1000", int'(mem[1000]), 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
